swu_seq: RTL

SWU_SEQ -- requirements
Module: swu_seq

---
 rtl/swu_pkg.sv | 36 +++
 rtl/swu_seq_if.sv | 29 ++
 rtl/swu_win_extract.sv | 18 +
 rtl/swu_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/swu_pkg.sv
// Shared constants, FSM state type and frame-length helper for the ECG
// sliding-window sequencer. Optional build macro: SWU_SEQ_ZERO_PAD_EN
// (frame is extended by zero-padded windows past the end of the stream).
package swu_pkg;

  localparam int WORD_W        = 32;
  localparam int WIN_W         = 7;
  localparam int STRIDE        = 2;
  localparam int WIN_PER_WORD  = 16;
  localparam int DEFAULT_DEPTH = 29;

  localparam int BUF_W    = 2 * WORD_W;
  localparam int OFF_W    = $clog2(WORD_W);
  localparam int IDX_W    = $clog2(BUF_W);
  localparam int SUB_W    = $clog2(WIN_PER_WORD);
  localparam int CNT_W    = 10;
  // Windows that would straddle the end of the stream without padding.
  localparam int TAIL_WIN = (WIN_W - 1) / STRIDE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_FIN
  } swu_state_t;

  // Number of windows emitted for a frame of n_words ROM words (n_words > 0).
  function automatic logic [CNT_W-1:0] frame_windows(input logic [CNT_W-1:0] n_words);
`ifdef SWU_SEQ_ZERO_PAD_EN
    return n_words * CNT_W'(WIN_PER_WORD);
`else
    return n_words * CNT_W'(WIN_PER_WORD) - CNT_W'(TAIL_WIN);
`endif
  endfunction

endpackage

// File: rtl/swu_seq_if.sv
// Bus bundle between the window sequencer, its sample ROM and the PE array.
// master = environment side, slave = sequencer side.
interface swu_seq_if #(
  parameter int ADDR_W = 5
) ();

  logic                             start;
  logic [ADDR_W:0]                  n_words;
  logic                             rom_en;
  logic [ADDR_W-1:0]                rom_addr;
  logic [swu_pkg::WORD_W-1:0]       rom_data;
  logic [swu_pkg::WIN_W-1:0]        win_data;
  logic                             win_valid;
  logic                             win_ready;
  logic                             busy;
  logic                             done;
  logic [swu_pkg::CNT_W-1:0]        win_cnt;

  modport master (
    output start, n_words, rom_data, win_ready,
    input  rom_en, rom_addr, win_data, win_valid, busy, done, win_cnt
  );

  modport slave (
    input  start, n_words, rom_data, win_ready,
    output rom_en, rom_addr, win_data, win_valid, busy, done, win_cnt
  );

endinterface

// File: rtl/swu_win_extract.sv
// Selects one MSB-first window from the two-word buffer; offset counts bits
// from the MSB of the upper (current) word.
module swu_win_extract
  import swu_pkg::*;
(
  input  logic [BUF_W-1:0] buffer,
  input  logic [OFF_W-1:0] offset,
  output logic [WIN_W-1:0] window
);

  genvar gi;
  generate
    for (gi = 0; gi < WIN_W; gi = gi + 1) begin : g_bit
      assign window[WIN_W-1-gi] = buffer[IDX_W'(BUF_W-1-gi) - IDX_W'(offset)];
    end
  endgenerate

endmodule

// File: rtl/swu_seq.sv
// Frame sequencer: streams ROM words through a two-word buffer and hands out
// 7-bit windows at stride 2 over a valid/ready handshake.
// Optional build macro: SWU_SEQ_ZERO_PAD_EN (16*N windows, tail read as 0);
// default build emits 16*N-3 windows.
module swu_seq
  import swu_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  swu_seq_if.slave bus
);

  localparam int             N_W     = ADDR_W + 1;
  localparam logic [N_W-1:0] DEPTH_N = N_W'(DEPTH);

  swu_state_t          state_reg, state_next;
  logic [N_W-1:0]      n_eff_reg;
  logic [N_W-1:0]      word_reg;        // ROM index of the word held in buf_hi_reg
  logic [CNT_W-1:0]    total_reg;
  logic [CNT_W-1:0]    win_cnt_reg;
  logic [SUB_W-1:0]    sub_reg;         // window index inside the current word
  logic [WORD_W-1:0]   buf_hi_reg, buf_lo_reg;
  logic                rom_en_reg;
  logic [ADDR_W-1:0]   rom_addr_reg;
  logic                data_vld_reg;    // rom_data carries a requested word
  logic                data_hi_reg;     // ...and it is word 0 (goes to buf_hi)

  logic [N_W-1:0]      n_clamped;
  logic [N_W-1:0]      word_plus2;
  logic                start_acc, xfer, last_xfer, word_done;
  logic                win_valid, busy, done;
  logic [WIN_W-1:0]    window;

  assign n_clamped  = (bus.n_words > DEPTH_N) ? DEPTH_N : bus.n_words;
  assign start_acc  = (state_reg == S_IDLE) && bus.start;
  assign xfer       = (state_reg == S_RUN) && bus.win_ready;
  assign last_xfer  = xfer && (win_cnt_reg == total_reg - CNT_W'(1));
  // Leaving the last window of a word (not the final one): shift the buffer.
  assign word_done  = xfer && (sub_reg == SUB_W'(WIN_PER_WORD - 1)) && !last_xfer;
  assign word_plus2 = word_reg + N_W'(2);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state and status decode
  always_comb begin
    state_next = state_reg;
    win_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start_acc) state_next = (n_clamped == '0) ? S_FIN : S_PRIME;
      end
      S_PRIME: begin
        busy = 1'b1;
        // Word 1 landed, or word 0 landed and it is the only word.
        if (data_vld_reg && (!data_hi_reg || n_eff_reg == N_W'(1))) state_next = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        win_valid = 1'b1;
        if (last_xfer) state_next = S_FIN;
      end
      S_FIN: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ROM read issue: word 0 on start, word 1 right after, then word k+2 when
  // leaving word k so it lands well before window 13 needs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_en_reg   <= 1'b0;
      rom_addr_reg <= '0;
    end else begin
      rom_en_reg <= 1'b0;
      if (start_acc && n_clamped != '0) begin
        rom_en_reg   <= 1'b1;
        rom_addr_reg <= '0;
      end else if (state_reg == S_PRIME && rom_en_reg && rom_addr_reg == '0 &&
                   n_eff_reg > N_W'(1)) begin
        rom_en_reg   <= 1'b1;
        rom_addr_reg <= ADDR_W'(1);
      end else if (word_done && word_plus2 < n_eff_reg) begin
        rom_en_reg   <= 1'b1;
        rom_addr_reg <= word_plus2[ADDR_W-1:0];
      end
    end
  end

  // Track which buffer half the returning ROM word belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_vld_reg <= 1'b0;
      data_hi_reg  <= 1'b0;
    end else begin
      data_vld_reg <= rom_en_reg;
      data_hi_reg  <= rom_en_reg && (rom_addr_reg == '0);
    end
  end

  // Two-word buffer: shift on word change; an empty lower half reads as zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_hi_reg <= '0;
      buf_lo_reg <= '0;
    end else if (word_done) begin
      buf_hi_reg <= buf_lo_reg;
      buf_lo_reg <= '0;
    end else if (data_vld_reg && data_hi_reg) begin
      buf_hi_reg <= bus.rom_data;
      buf_lo_reg <= '0;
    end else if (data_vld_reg) begin
      buf_lo_reg <= bus.rom_data;
    end
  end

  // Frame bookkeeping: length capture on start, window/word counters on transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_eff_reg   <= '0;
      total_reg   <= '0;
      win_cnt_reg <= '0;
      sub_reg     <= '0;
      word_reg    <= '0;
    end else if (start_acc) begin
      n_eff_reg   <= n_clamped;
      total_reg   <= frame_windows(CNT_W'(n_clamped));
      win_cnt_reg <= '0;
      sub_reg     <= '0;
      word_reg    <= '0;
    end else if (xfer) begin
      win_cnt_reg <= win_cnt_reg + CNT_W'(1);
      sub_reg     <= sub_reg + SUB_W'(1);
      if (word_done) word_reg <= word_reg + N_W'(1);
    end
  end

  swu_win_extract u_extract (
    .buffer (BUF_W'({buf_hi_reg, buf_lo_reg})),
    .offset (OFF_W'(sub_reg) * OFF_W'(STRIDE)),
    .window (window)
  );

  assign bus.rom_en    = rom_en_reg;
  assign bus.rom_addr  = rom_addr_reg;
  assign bus.win_data  = window;
  assign bus.win_valid = win_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.win_cnt   = win_cnt_reg;

endmodule
